// File: rtl/lcd_timing_pattern_gen.sv
// LCD RGB timing generator with runtime-selectable test patterns.
// Counters drive DE/HS/VS and a pattern source; every output is registered.
module lcd_timing_pattern_gen #(
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 40,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int SYNC_POL = 0,
    parameter int CD       = 8,
    parameter int GRID     = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [3*CD-1:0]               solid_rgb,
    output logic                          lcd_de,
    output logic                          lcd_hs,
    output logic                          lcd_vs,
    output logic [3*CD-1:0]               lcd_rgb,
    output logic                          frame_start,
    output logic [$clog2(H_ACTIVE)-1:0]   pix_x,
    output logic [$clog2(V_ACTIVE)-1:0]   pix_y
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int GW      = $clog2(GRID);
    localparam int CW      = 3 * CD;
    localparam int H_BAR   = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SE   = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ST   = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_END  = HW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SE   = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ST   = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [GW-1:0] G_LAST = GW'(GRID - 1);
    localparam logic          SP     = 1'(SYNC_POL);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [GW-1:0] r_gx;
    logic [GW-1:0] r_gy;
    logic [1:0]    r_mode;

    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic [GW-1:0] w_gx_nxt;
    logic [GW-1:0] w_gy_nxt;
    logic [HW-1:0] w_x;
    logic [VW-1:0] w_y;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_org;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_h_vis;
    logic          w_v_vis;
    logic          w_de;
    logic [2:0]    w_bar;
    logic [CD-1:0] w_grey;
    logic [CW-1:0] w_pat;

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);
    assign w_org    = (r_h == '0) && (r_v == '0);

    assign w_h_nxt = w_h_last ? '0 : r_h + 1'b1;
    assign w_v_nxt = !w_h_last ? r_v :
                     (w_v_last ? '0 : r_v + 1'b1);

    // Grid phase counters restart at the first active column/row
    assign w_gx_nxt = (w_h_nxt == H_ST) ? '0 :
                      ((r_gx == G_LAST) ? '0 : r_gx + 1'b1);
    assign w_gy_nxt = !w_h_last ? r_gy :
                      ((w_v_nxt == V_ST) ? '0 :
                       ((r_gy == G_LAST) ? '0 : r_gy + 1'b1));

    assign w_hs_act = (r_h < H_SE);
    assign w_vs_act = (r_v < V_SE);
    assign w_h_vis  = (r_h >= H_ST) && (r_h < H_END);
    assign w_v_vis  = (r_v >= V_ST) && (r_v < V_END);
    assign w_de     = w_h_vis && w_v_vis;

    assign w_x    = r_h - H_ST;
    assign w_y    = r_v - V_ST;
    assign w_grey = CD'(w_x);

    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_x >= HW'(k * H_BAR)) begin
                w_bar = 3'(k);
            end
        end
    end

    // Bar order white..black maps to R=~k[1], G=~k[2], B=~k[0]
    always_comb begin
        w_pat = '0;
        case (r_mode)
            2'd0: w_pat = {{CD{~w_bar[1]}}, {CD{~w_bar[2]}}, {CD{~w_bar[0]}}};
            2'd1: w_pat = ((r_gx == '0) || (r_gy == '0)) ? '1 : '0;
            2'd2: w_pat = {3{w_grey}};
            2'd3: w_pat = solid_rgb;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h         <= '0;
            r_v         <= '0;
            r_gx        <= '0;
            r_gy        <= '0;
            r_mode      <= 2'd0;
            lcd_de      <= 1'b0;
            lcd_hs      <= ~SP;
            lcd_vs      <= ~SP;
            lcd_rgb     <= '0;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            if (w_org) begin
                r_mode <= mode;
            end
            if (!en) begin
                r_h         <= '0;
                r_v         <= '0;
                r_gx        <= '0;
                r_gy        <= '0;
                lcd_de      <= 1'b0;
                lcd_hs      <= ~SP;
                lcd_vs      <= ~SP;
                lcd_rgb     <= '0;
                frame_start <= 1'b0;
                pix_x       <= '0;
                pix_y       <= '0;
            end else begin
                r_h         <= w_h_nxt;
                r_v         <= w_v_nxt;
                r_gx        <= w_gx_nxt;
                r_gy        <= w_gy_nxt;
                lcd_de      <= w_de;
                lcd_hs      <= w_hs_act ? SP : ~SP;
                lcd_vs      <= w_vs_act ? SP : ~SP;
                lcd_rgb     <= w_de ? w_pat : '0;
                frame_start <= w_org;
                pix_x       <= w_de ? XW'(w_x) : '0;
                pix_y       <= w_de ? YW'(w_y) : '0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Directed bench for lcd_timing_pattern_gen on a 22x7 geometry.
// Four frames cover each pattern, then en drop and async reset.
module tb_lcd_timing_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid = 24'h0;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic        fs;
    logic [3:0]  px;
    logic [1:0]  py;

    int n_checks = 0;
    int n_fail = 0;

    lcd_timing_pattern_gen #(
        .H_SYNC(2), .H_BACK(2), .H_ACTIVE(16), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
        .SYNC_POL(0), .CD(8), .GRID(4)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .en(en),
        .mode(mode),
        .solid_rgb(solid),
        .lcd_de(de),
        .lcd_hs(hs),
        .lcd_vs(vs),
        .lcd_rgb(rgb),
        .frame_start(fs),
        .pix_x(px),
        .pix_y(py)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pat(input int x, input int y,
                                        input int m, input logic [23:0] s);
        logic [7:0] xv;
        xv = 8'(x);
        case (m)
            0: begin
                case (x / 2)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return ((x % 4 == 0) || (y % 4 == 0)) ? 24'hFFFFFF : 24'h0;
            2: return {xv, xv, xv};
            default: return s;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_de"}, 32'(de), 32'd0);
        check({tag, "_hs"}, 32'(hs), 32'd1);
        check({tag, "_vs"}, 32'(vs), 32'd1);
        check({tag, "_rgb"}, 32'(rgb), 32'd0);
        check({tag, "_fs"}, 32'(fs), 32'd0);
        check({tag, "_px"}, 32'(px), 32'd0);
        check({tag, "_py"}, 32'(py), 32'd0);
    endtask

    initial begin
        int h, v, x, y;
        int dec, hsc, vsc, fsc;
        logic e_de;
        logic [23:0] s_cur;

        repeat (3) tick();
        check_idle("rst");

        rst_n = 1'b1;
        for (int f = 0; f < 4; f++) begin
            dec = 0; hsc = 0; vsc = 0; fsc = 0;
            for (int t = 0; t < 154; t++) begin
                if (t == 60 && f < 3) mode = 2'(f + 1);
                if (t == 60 && f == 2) solid = 24'h123456;
                if (t == 88 && f == 3) solid = 24'h654321;
                s_cur = solid;
                tick();
                h = t % 22;
                v = t / 22;
                e_de = (h >= 4) && (h < 20) && (v >= 2) && (v < 6);
                x = e_de ? h - 4 : 0;
                y = e_de ? v - 2 : 0;
                check("hs", 32'(hs), (h < 2) ? 32'd0 : 32'd1);
                check("vs", 32'(vs), (v < 1) ? 32'd0 : 32'd1);
                check("de", 32'(de), 32'(e_de));
                check("fs", 32'(fs), (t == 0) ? 32'd1 : 32'd0);
                check("px", 32'(px), 32'(x));
                check("py", 32'(py), 32'(y));
                check("rgb", 32'(rgb),
                      e_de ? 32'(pat(x, y, f, s_cur)) : 32'd0);
                dec += int'(de);
                hsc += int'(!hs);
                vsc += int'(!vs);
                fsc += int'(fs);
            end
            check("de_cnt", 32'(dec), 32'd64);
            check("hs_cnt", 32'(hsc), 32'd14);
            check("vs_cnt", 32'(vsc), 32'd22);
            check("fs_cnt", 32'(fsc), 32'd1);
        end

        // Frame 5: drop en mid-line inside DE
        repeat (54) tick();
        check("pre_en_de", 32'(de), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_idle("en0");
        end
        en = 1'b1;
        tick();
        check("restart_fs", 32'(fs), 32'd1);
        check("restart_hs", 32'(hs), 32'd0);
        check("restart_vs", 32'(vs), 32'd0);
        check("restart_de", 32'(de), 32'd0);
        tick();
        check("restart_fs1", 32'(fs), 32'd0);
        repeat (47) tick();
        check("solid_de", 32'(de), 32'd1);
        check("solid_rgb", 32'(rgb), 32'h654321);
        check("solid_px", 32'(px), 32'd0);
        check("solid_py", 32'(py), 32'd0);

        rst_n = 1'b0;
        #1;
        check("arst_de", 32'(de), 32'd0);
        check("arst_rgb", 32'(rgb), 32'd0);
        check("arst_hs", 32'(hs), 32'd1);
        check("arst_vs", 32'(vs), 32'd1);
        check("arst_px", 32'(px), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
